// File: rtl/boot_loader_pkg.sv
// boot_pkg: command codes and loader state encoding shared by the boot loader files.
package boot_pkg;
    localparam logic [7:0] CMD_IMEM = 8'h01;
    localparam logic [7:0] CMD_DMEM = 8'h02;
    localparam logic [7:0] CMD_RUN  = 8'hA5;
    typedef enum logic [1:0] {HDR, LOAD, CKSUM, RUN} boot_state_t;
endpackage

// File: rtl/boot_loader_if.sv
// boot_loader_if: byte stream input plus memory write, run and status outputs of the loader.
interface boot_loader_if #(parameter int AW = 6);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          imem_we;
    logic          dmem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_run;
    logic          busy;
    logic          err;
    modport slave (input in_valid, in_data,
                   output in_ready, imem_we, dmem_we, mem_addr, mem_wdata, cpu_run, busy, err);
    modport master (output in_valid, in_data,
                    input in_ready, imem_we, dmem_we, mem_addr, mem_wdata, cpu_run, busy, err);
endinterface

// File: rtl/boot_loader_byte_packer.sv
// byte_packer: big-endian byte-to-word shifter; done flags the 4th accepted byte of a word.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] word,
    output logic        done
);
    logic [23:0] sh;
    logic [1:0]  n;
    assign word = {sh, data};
    assign done = en && n == 2'd3;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sh <= '0;
            n  <= '0;
        end else if (clr) begin
            sh <= '0;
            n  <= '0;
        end else if (en) begin
            sh <= word[23:0];
            n  <= n + 2'd1;
        end
    end
endmodule

// File: rtl/boot_loader.sv
// boot_loader: stream-driven imem/dmem preload and CPU run release.
// Define BOOT_CHECKSUM_EN to require a trailing XOR checksum byte after each load.
module boot_loader import boot_pkg::*; #(
    parameter int AW    = 6,
    parameter int CNT_W = 12
) (
    input logic clk,
    input logic reset,
    boot_loader_if.slave bus
);
    boot_state_t      st;
    logic             tgt;
    logic [AW-1:0]    addr;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      word;
    logic             done;
    logic             acc;
    assign acc = bus.in_valid && bus.in_ready;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0] cks;
`endif
    byte_packer u_packer (
        .clk  (clk),
        .reset(reset),
        .clr  (st == RUN),
        .en   (acc && st != CKSUM),
        .data (bus.in_data),
        .word (word),
        .done (done)
    );
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st            <= HDR;
            tgt           <= 1'b0;
            addr          <= '0;
            cnt           <= '0;
            bus.in_ready  <= 1'b0;
            bus.imem_we   <= 1'b0;
            bus.dmem_we   <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.cpu_run   <= 1'b0;
            bus.busy      <= 1'b0;
            bus.err       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            cks           <= '0;
`endif
        end else begin
            bus.imem_we  <= 1'b0;
            bus.dmem_we  <= 1'b0;
            bus.in_ready <= st != RUN;
            case (st)
                HDR: if (done) begin
                    if (word[31:24] == CMD_IMEM || word[31:24] == CMD_DMEM) begin
                        if (word[CNT_W-1:0] != '0) begin
                            st       <= LOAD;
                            tgt      <= word[31:24] == CMD_DMEM;
                            addr     <= word[12 +: AW];
                            cnt      <= word[CNT_W-1:0];
                            bus.busy <= 1'b1;
`ifdef BOOT_CHECKSUM_EN
                            cks      <= '0;
`endif
                        end
                    end else if (word[31:24] == CMD_RUN) begin
                        st           <= RUN;
                        bus.in_ready <= 1'b0;
                        bus.cpu_run  <= 1'b1;
                    end else begin
                        bus.err <= 1'b1;
                    end
                end
                LOAD: begin
`ifdef BOOT_CHECKSUM_EN
                    if (acc) cks <= cks ^ bus.in_data;
`endif
                    if (done) begin
                        bus.imem_we   <= !tgt;
                        bus.dmem_we   <= tgt;
                        bus.mem_addr  <= addr;
                        bus.mem_wdata <= word;
                        addr          <= addr + AW'(1);
                        cnt           <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
`ifdef BOOT_CHECKSUM_EN
                            st <= CKSUM;
`else
                            st       <= HDR;
                            bus.busy <= 1'b0;
`endif
                        end
                    end
                end
`ifdef BOOT_CHECKSUM_EN
                CKSUM: if (acc) begin
                    if (bus.in_data != cks) bus.err <= 1'b1;
                    st       <= HDR;
                    bus.busy <= 1'b0;
                end
`endif
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: scoreboard bench for boot_loader; expected writes are queued as bytes are driven.
module tb_boot_loader;
    localparam int AW = 6;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    boot_loader_if #(.AW(AW)) bif();
    boot_loader #(.AW(AW), .CNT_W(12)) dut (.clk(clk), .reset(reset), .bus(bif.slave));
    typedef struct {
        logic          d;
        logic [AW-1:0] a;
        logic [31:0]   w;
    } wr_t;
    wr_t q[$];
    wr_t m;
    int checks = 0;
    int failures = 0;
    always @(negedge clk) begin
        if (bif.imem_we || bif.dmem_we) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got imem=%0b dmem=%0b addr=%0d data=%h", bif.imem_we, bif.dmem_we, bif.mem_addr, bif.mem_wdata);
            end else begin
                m = q.pop_front();
                if ({bif.dmem_we, bif.imem_we, bif.mem_addr, bif.mem_wdata} !== {m.d, !m.d, m.a, m.w}) begin
                    failures++;
                    $display("FAIL write got dmem=%0b imem=%0b addr=%0d data=%h exp dmem=%0b addr=%0d data=%h",
                             bif.dmem_we, bif.imem_we, bif.mem_addr, bif.mem_wdata, m.d, m.a, m.w);
                end
            end
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
    function automatic logic [7:0] xw(input logic [31:0] w);
        return w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    endfunction
    task automatic push(input logic d, input logic [AW-1:0] a, input logic [31:0] w);
        wr_t e;
        e.d = d;
        e.a = a;
        e.w = w;
        q.push_back(e);
    endtask
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_data  = b;
        while (!bif.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!bif.in_ready) begin
            failures++;
            $display("FAIL send_timeout byte=%h in_ready=%b exp 1", b, bif.in_ready);
            bif.in_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask
    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    endtask
    task automatic drain(input string name);
        repeat (3) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing_writes got pending=%0d exp 0", name, q.size());
            q.delete();
        end
    endtask
    task automatic send_load(input logic [7:0] cmd, input logic [11:0] a, input int n, input logic [31:0] w0, input logic [31:0] w1);
        logic [31:0] ws[2];
        logic [7:0] x = 8'h00;
        ws[0] = w0;
        ws[1] = w1;
        for (int i = 0; i < n; i++) push(cmd == 8'h02, AW'(int'(a) + i), ws[i]);
        send_word({cmd, a, 12'(n)});
        @(negedge clk);
        bif.in_valid = 1'b0;
        checks++;
        if (bif.busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_set got %b exp 1", bif.busy);
        end
        for (int i = 0; i < n; i++) begin
            send_word(ws[i]);
            x ^= xw(ws[i]);
        end
        @(negedge clk);
        bif.in_valid = 1'b0;
        checks++;
        if ((bif.imem_we | bif.dmem_we) !== 1'b1) begin
            failures++;
            $display("FAIL last_strobe got %b exp 1", bif.imem_we | bif.dmem_we);
        end
        checks++;
`ifdef BOOT_CHECKSUM_EN
        if (bif.busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_before_cksum got %b exp 1", bif.busy);
        end
        send_byte(x);
        @(negedge clk);
        bif.in_valid = 1'b0;
        checks++;
`endif
        if (bif.busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_drop got %b exp 0", bif.busy);
        end
        drain("load");
    endtask
    task automatic test_reset;
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({bif.in_ready, bif.imem_we, bif.dmem_we, bif.cpu_run, bif.busy, bif.err} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got %b exp 000000", {bif.in_ready, bif.imem_we, bif.dmem_we, bif.cpu_run, bif.busy, bif.err});
        end
        checks++;
        if ({bif.mem_addr, bif.mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_bus got addr=%0d data=%h exp 0", bif.mem_addr, bif.mem_wdata);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bif.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_reset got %b exp 1", bif.in_ready);
        end
    endtask
    task automatic test_imem;
        send_load(8'h01, 12'h000, 2, 32'h20020005, 32'h2003000C);
    endtask
    task automatic test_dmem_wrap;
        send_load(8'h02, 12'h03F, 2, 32'hAAAAAAAA, 32'hBBBBBBBB);
    endtask
    task automatic test_back_to_back;
        push(1'b1, 6'd10, 32'h01020304);
        push(1'b0, 6'd20, 32'hDEADBEEF);
        send_word(32'h0200A001);
        send_word(32'h01020304);
`ifdef BOOT_CHECKSUM_EN
        send_byte(xw(32'h01020304));
`endif
        send_word(32'h01014000);
        send_word(32'h01014001);
        send_word(32'hDEADBEEF);
`ifdef BOOT_CHECKSUM_EN
        send_byte(xw(32'hDEADBEEF));
`endif
        @(negedge clk);
        bif.in_valid = 1'b0;
        drain("b2b");
        checks++;
        if (bif.err !== 1'b0 || bif.busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_status got err=%b busy=%b exp 0 0", bif.err, bif.busy);
        end
    endtask
    task automatic test_err;
        send_word(32'h7E000001);
        @(negedge clk);
        bif.in_valid = 1'b0;
        checks++;
        if (bif.err !== 1'b1 || bif.busy !== 1'b0) begin
            failures++;
            $display("FAIL bad_cmd got err=%b busy=%b exp 1 0", bif.err, bif.busy);
        end
        send_load(8'h01, 12'h000, 1, 32'h11223344, 32'h0);
        checks++;
        if (bif.err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got %b exp 1", bif.err);
        end
    endtask
    task automatic test_abort;
        send_word(32'h01000002);
        send_byte(8'h20);
        send_byte(8'h02);
        @(negedge clk);
        bif.in_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (bif.busy !== 1'b1) begin
            failures++;
            $display("FAIL stall_hold got busy=%b exp 1", bif.busy);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({bif.busy, bif.err, bif.in_ready} !== 3'b000) begin
            failures++;
            $display("FAIL abort_reset got busy/err/ready=%b exp 000", {bif.busy, bif.err, bif.in_ready});
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bif.in_ready !== 1'b1 || bif.busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_release got ready=%b busy=%b exp 1 0", bif.in_ready, bif.busy);
        end
        send_load(8'h01, 12'h005, 1, 32'hCAFEF00D, 32'h0);
    endtask
`ifdef BOOT_CHECKSUM_EN
    task automatic test_cksum;
        for (int k = 0; k < 2; k++) begin
            push(1'b0, 6'd0, 32'h12345678);
            send_word(32'h01000001);
            send_word(32'h12345678);
            send_byte(k == 0 ? 8'h08 : 8'h09);
            @(negedge clk);
            bif.in_valid = 1'b0;
            checks++;
            if (bif.err !== (k == 1) || bif.busy !== 1'b0) begin
                failures++;
                $display("FAIL cksum_%0d got err=%b busy=%b exp err=%0b busy=0", k, bif.err, bif.busy, k == 1);
            end
            drain("cksum");
        end
    endtask
`endif
    task automatic test_run;
        send_word(32'hA5000000);
        @(negedge clk);
        bif.in_data = 8'h01;
        checks++;
        if (bif.cpu_run !== 1'b1 || bif.in_ready !== 1'b0) begin
            failures++;
            $display("FAIL run_enter got run=%b ready=%b exp 1 0", bif.cpu_run, bif.in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bif.in_ready !== 1'b0 || bif.cpu_run !== 1'b1 || bif.busy !== 1'b0) begin
                failures++;
                $display("FAIL run_hold got ready=%b run=%b busy=%b exp 0 1 0", bif.in_ready, bif.cpu_run, bif.busy);
            end
        end
        bif.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        checks++;
        if (bif.cpu_run !== 1'b0) begin
            failures++;
            $display("FAIL run_reset got %b exp 0", bif.cpu_run);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (bif.in_ready !== 1'b1 || bif.cpu_run !== 1'b0) begin
            failures++;
            $display("FAIL run_release got ready=%b run=%b exp 1 0", bif.in_ready, bif.cpu_run);
        end
        send_load(8'h02, 12'h007, 1, 32'h0BADF00D, 32'h0);
    endtask
    initial begin
        bif.in_valid = 1'b0;
        bif.in_data  = 8'h00;
        test_reset();
        test_imem();
        test_dmem_wrap();
        test_back_to_back();
        test_err();
        test_abort();
`ifdef BOOT_CHECKSUM_EN
        test_cksum();
`endif
        test_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
